tag_gen_engine: RTL
===================

Name: tag_gen_engine

Overview:
- Parametrised, iterative successor to the single-word tag generator.
- Splits a DATA_W-bit word into NUM_BLK blocks of TAG_W bits. Each block gets a key-controlled flip and rotate-left, and the results are XOR-folded into a TAG_W tag, one block per cycle.
- Key is a runtime register rather than a constant.
- Valid/ready handshake on input and output, with backpressure.
- Sits between the memory write path and the tag store.

Parameters:
- DATA_W, 32, input word width; must be a multiple of TAG_W.
- TAG_W, 8, tag/block width; power of two, at least 4.
- NUM_BLK, DATA_W/TAG_W, derived block count; at least 2.
- KEY_RESET, all-zero, reset value of the key register (width KEY_W).
- Derived constants:
  - KS = 1+$clog2(TAG_W), key slice width per block.
  - KEY_W = NUM_BLK*KS.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- key_wr  in  1  load key_in into key register
- key_in  in  KEY_W  new key
- in_valid  in  1  data word offered
- in_ready  out  1  engine can accept a word
- in_data  in  DATA_W  word to tag
- out_valid  out  1  tag available
- out_ready  in  1  consumer takes tag
- out_tag  out  TAG_W  result tag

Behaviour:
- Reset: reset, synchronous, active-high.
  - Takes priority over every other input.
  - Forces state IDLE, key register to KEY_RESET, accumulator and out_tag to 0, out_valid to 0.
  - Reset mid-operation discards the word in flight; no tag is emitted.
- Block i is in_data[i*TAG_W +: TAG_W]. Key slice i is key[i*KS +: KS].
  - Bit KS-1 is the flip enable: invert the block when 1.
  - Bits KS-2:0 are the rotate amount r, 0..TAG_W-1. Rotate left by r; r=0 means no rotation.
- Tag = XOR over i of rotl(flip_i(block_i), r_i), with the accumulator starting at 0.
- State machine:
  - IDLE: in_ready=1. When in_valid&in_ready, latch in_data and a snapshot of the key; clear the block counter and accumulator; go to BUSY.
  - BUSY: in_ready=0. Each cycle, acc <= acc ^ xform(block[cnt], slice[cnt]) and cnt++. After block NUM_BLK-1, load out_tag from the final acc value, set out_valid=1 and go to DONE.
  - DONE: out_valid=1 and out_tag held stable until out_ready. On out_valid&out_ready, out_valid <= 0 and go to IDLE.
- Latency: out_valid rises exactly NUM_BLK edges after the accepting edge. No overlap between words; minimum spacing between accepts is NUM_BLK+2 cycles.
- Key updates:
  - key_wr is honoured in any state. It affects only words accepted on a later edge.
  - key_wr coincident with an accept: the word uses the old key.
  - The word in flight always uses its snapshot.
- in_data is sampled only on the accept edge; changes while BUSY are ignored.
- out_ready while out_valid=0 has no effect.
- Block counter is $clog2(NUM_BLK) bits (min 1) and saturates in DONE.

Optional Feature:
- TAG_CHECK_EN defined:
  - Adds input in_exp_tag [TAG_W], latched on accept alongside in_data.
  - Adds output out_mismatch [1], valid with out_valid, equal to (out_tag != latched expected tag). Reset value 0.
- TAG_CHECK_EN undefined: neither port exists; the rest of the behaviour is unchanged.

Decomposition:
- Package tag_gen_pkg:
  - State enum typedef (IDLE/BUSY/DONE).
  - Function key_slice_w(tag_w) returning 1+$clog2(tag_w).
- One combinational sub-module, tag_block_xform: ports blk_in[TAG_W], flip, rot[KS-1], blk_out[TAG_W].
  - Instantiated once and muxed by the counter, not NUM_BLK times.

Test Plan:
- Defaults, key=16'hDEAD (slices D,A,E,D: all flip, rotates 5,2,6,5), data 32'h0000_0000 -> out_tag 8'h00, out_valid exactly 4 edges after accept.
- Key 16'hDEAD, data 32'h0000_00FF -> out_tag 8'hFF.
- Key 16'h0003 (block0 rot 3, others identity), data 32'h0000_0001 -> out_tag 8'h08. Then key 16'h0000, same data -> 8'h01.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_tag stable, in_ready=0 throughout, a second in_valid is not accepted. Release -> in_ready=1 the following cycle.
- key_wr to 16'h0000 on the same edge as the accept of data 32'h0000_00FF under key 16'hDEAD -> tag 8'hFF (old key). The next word, 32'h0000_0001, -> 8'h01.
- reset asserted for 1 cycle while BUSY -> out_valid stays 0 and key returns to KEY_RESET. Next word 32'h0000_0001 with KEY_RESET=0 -> 8'h01. With TAG_CHECK_EN, in_exp_tag 8'h02 -> out_mismatch=1.

Source files
------------

// File: rtl/tag_gen_pkg.sv
// tag_gen_pkg: shared state encoding and key-slice width helper for the tag engine.
package tag_gen_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int key_slice_w(input int tag_w);
    return 1 + $clog2(tag_w);
  endfunction
endpackage

// File: rtl/tag_block_xform.sv
// tag_block_xform: optional invert then rotate-left of one TAG_W block.
module tag_block_xform #(
  parameter int TAG_W = 8,
  parameter int KS    = 4
) (
  input  logic [TAG_W-1:0] blk_in,
  input  logic             flip,
  input  logic [KS-2:0]    rot,
  output logic [TAG_W-1:0] blk_out
);
  logic [TAG_W-1:0]   f;
  logic [2*TAG_W-1:0] d;
  assign f = flip ? ~blk_in : blk_in;
  // Shifting the doubled word leaves the rotated value in the upper half.
  assign d = {f, f} << rot;
  assign blk_out = d[2*TAG_W-1 -: TAG_W];
endmodule

// File: rtl/tag_gen_engine.sv
// tag_gen_engine: iterative keyed XOR-fold tag generator, one block per cycle.
// Optional TAG_CHECK_EN adds in_exp_tag/out_mismatch comparison against an expected tag.
module tag_gen_engine
  import tag_gen_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 8,
  parameter int NUM_BLK = DATA_W / TAG_W,
  localparam int KS     = key_slice_w(TAG_W),
  localparam int KEY_W  = NUM_BLK * KS,
  parameter logic [KEY_W-1:0] KEY_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag
`ifdef TAG_CHECK_EN
  ,
  input  logic [TAG_W-1:0]  in_exp_tag,
  output logic              out_mismatch
`endif
);
  localparam int CW = NUM_BLK > 1 ? $clog2(NUM_BLK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BLK - 1);
  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d, snap_q, snap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TAG_W-1:0]  acc_q, acc_d, tag_q, tag_d, blk, xf, nxt;
  logic [KS-1:0]     slc;
  logic              accept;
  assign blk = data_q[cnt_q*TAG_W +: TAG_W];
  assign slc = snap_q[cnt_q*KS +: KS];
  assign nxt = acc_q ^ xf;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_tag   = tag_q;
  assign accept    = in_ready && in_valid;
  tag_block_xform #(.TAG_W(TAG_W), .KS(KS)) u_xf (
    .blk_in (blk),
    .flip   (slc[KS-1]),
    .rot    (slc[KS-2:0]),
    .blk_out(xf)
  );
  always_comb begin
    state_d = state_q;
    key_d   = key_wr ? key_in : key_q;
    snap_d  = snap_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    tag_d   = tag_q;
    if (accept) begin
      state_d = BUSY;
      data_d  = in_data;
      snap_d  = key_q;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == BUSY) begin
      acc_d   = nxt;
      cnt_d   = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
      tag_d   = cnt_q == LAST ? nxt : tag_q;
      state_d = cnt_q == LAST ? DONE : BUSY;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= KEY_RESET;
      snap_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
    end
  end
`ifdef TAG_CHECK_EN
  logic [TAG_W-1:0] exp_q;
  logic             mis_q;
  assign out_mismatch = mis_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (accept) exp_q <= in_exp_tag;
      if (state_q == BUSY && cnt_q == LAST) mis_q <= nxt != exp_q;
    end
  end
`endif
endmodule
